// File: rtl/mem_arbiter.sv
// Byte-wide memory port arbiter for three requesters (loader, cpu, debug).
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority 0 > 1 > 2.
module mem_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [2:0]  req_we,
    input  logic [95:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  grant,
    output logic [2:0]  done,
    output logic        err,
    output logic [7:0]  rdata,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_data_in,
    input  logic [7:0]  mem_data_out,
    output logic        mem_read_en,
    output logic        mem_write_en,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, GAP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [2:0]  grant_r, grant_s;
    logic [2:0]  done_r, done_s;
    logic        err_r, err_s;
    logic        eflag_r, eflag_s;
    logic [7:0]  rdata_r, rdata_s;
    logic [31:0] addr_r, addr_s;
    logic [7:0]  din_r, din_s;
    logic        rd_r, rd_s;
    logic        wr_r, wr_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [2:0]  win_s;
    logic        win_we_s;
    logic [31:0] win_addr_s;
    logic [7:0]  win_wdata_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // ptr_r is the first port searched, i.e. the port after the last grant.
    logic [1:0]  ptr_r, ptr_s;
`endif

    // Winner selection among the currently requesting ports.
    always_comb begin
        win_s = 3'b000;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        case (ptr_r)
            2'd1: begin
                if (req[1])      win_s = 3'b010;
                else if (req[2]) win_s = 3'b100;
                else if (req[0]) win_s = 3'b001;
                else             win_s = 3'b000;
            end
            2'd2: begin
                if (req[2])      win_s = 3'b100;
                else if (req[0]) win_s = 3'b001;
                else if (req[1]) win_s = 3'b010;
                else             win_s = 3'b000;
            end
            default: begin
                if (req[0])      win_s = 3'b001;
                else if (req[1]) win_s = 3'b010;
                else if (req[2]) win_s = 3'b100;
                else             win_s = 3'b000;
            end
        endcase
`else
        if (req[0])      win_s = 3'b001;
        else if (req[1]) win_s = 3'b010;
        else if (req[2]) win_s = 3'b100;
        else             win_s = 3'b000;
`endif
    end

    // Route the winner's transaction fields.
    always_comb begin
        case (win_s)
            3'b010: begin
                win_we_s    = req_we[1];
                win_addr_s  = req_addr[63:32];
                win_wdata_s = req_wdata[15:8];
            end
            3'b100: begin
                win_we_s    = req_we[2];
                win_addr_s  = req_addr[95:64];
                win_wdata_s = req_wdata[23:16];
            end
            default: begin
                win_we_s    = req_we[0];
                win_addr_s  = req_addr[31:0];
                win_wdata_s = req_wdata[7:0];
            end
        endcase
    end

    // Next-state and next-output logic; outputs lag the state by one edge.
    always_comb begin
        state_s = state_r;
        grant_s = grant_r;
        done_s  = 3'b000;
        err_s   = err_r;
        eflag_s = eflag_r;
        rdata_s = rdata_r;
        addr_s  = addr_r;
        din_s   = din_r;
        rd_s    = rd_r;
        wr_s    = wr_r;
        cnt_s   = cnt_r;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        ptr_s   = ptr_r;
`endif
        case (state_r)
            IDLE: begin
                if (req != 3'b000) begin
                    state_s = BUSY;
                    grant_s = win_s;
                    addr_s  = win_addr_s;
                    din_s   = win_wdata_s;
                    rd_s    = ~win_we_s;
                    wr_s    = win_we_s;
                    cnt_s   = 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                    case (win_s)
                        3'b001:  ptr_s = 2'd1;
                        3'b010:  ptr_s = 2'd2;
                        default: ptr_s = 2'd0;
                    endcase
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (rd_r) begin
                        rdata_s = mem_data_out;
                    end else begin
                        rdata_s = rdata_r;
                    end
                    rd_s    = 1'b0;
                    wr_s    = 1'b0;
                    state_s = DONE;
                end else if (cnt_r == TO_LAST) begin
                    rd_s    = 1'b0;
                    wr_s    = 1'b0;
                    rdata_s = 8'h00;
                    eflag_s = 1'b1;
                    state_s = DONE;
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end
            DONE: begin
                done_s  = grant_r;
                err_s   = eflag_r;
                state_s = GAP;
            end
            GAP: begin
                grant_s = 3'b000;
                err_s   = 1'b0;
                eflag_s = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            grant_r <= 3'b000;
            done_r  <= 3'b000;
            err_r   <= 1'b0;
            eflag_r <= 1'b0;
            rdata_r <= 8'h00;
            addr_r  <= 32'h0000_0000;
            din_r   <= 8'h00;
            rd_r    <= 1'b0;
            wr_r    <= 1'b0;
            cnt_r   <= 8'd0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_r   <= 2'd0;
`endif
        end else begin
            state_r <= state_s;
            grant_r <= grant_s;
            done_r  <= done_s;
            err_r   <= err_s;
            eflag_r <= eflag_s;
            rdata_r <= rdata_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
            rd_r    <= rd_s;
            wr_r    <= wr_s;
            cnt_r   <= cnt_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr_r   <= ptr_s;
`endif
        end
    end

    assign grant        = grant_r;
    assign done         = done_r;
    assign err          = err_r;
    assign rdata        = rdata_r;
    assign mem_addr     = addr_r;
    assign mem_data_in  = din_r;
    assign mem_read_en  = rd_r;
    assign mem_write_en = wr_r;

endmodule
